brightness_gain_ramp: RTL
=========================

// Module: brightness_gain_ramp
// PURPOSE
//  Parametrised per-channel brightness scaler for the video pixel path; successor to the fixed 4-bit RGB gain stage.
//  Applies fixed-point gain (level+1) with saturation to NUM_CH channels of CH_W bits; valid/ready streaming.
//  Gain ramps toward target by RAMP_STEP once per frame (at SOF) to avoid visible brightness jumps.
//  Sits between the camera/pixel source and the VGA/output formatter.
// PARAMETERS
//  CH_W      4  bits per colour channel
//  NUM_CH    3  channels per pixel, packed MSB-first (ch NUM_CH-1 at top)
//  LVL_W     3  width of level input; target gain = level+1
//  FRAC_W    2  fractional bits of internal gain (1 LSB = 2^-FRAC_W)
//  RAMP_STEP 1  gain LSBs moved per frame; 0 = jump to target immediately
// PORTS
//  clk        in   1                  pixel clock
//  rst_n      in   1                  synchronous reset, active-low
//  in_data    in   NUM_CH*CH_W        input pixel
//  in_sof     in   1                  marks first pixel of frame (qualified by in_valid)
//  in_valid   in   1                  input pixel valid
//  in_ready   out  1                  block can accept pixel
//  level      in   LVL_W              brightness level; sampled only on accepted SOF pixel
//  out_data   out  NUM_CH*CH_W        scaled pixel
//  out_sof    out  1                  SOF passed through, aligned with out_data
//  out_valid  out  1                  output pixel valid
//  out_ready  in   1                  downstream accepts
//  gain_cur   out  LVL_W+FRAC_W+1     current gain (fixed point, FRAC_W frac bits)
//  ramp_busy  out  1                  1 while gain_cur != target
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): out_valid=0, out_data=0, out_sof=0, gain_cur=1.0 (1<<FRAC_W),
//   target=1.0, state=HOLD, ramp_busy=0; pipeline flushed; in_ready=1 the cycle after reset deasserts.
//   Reset mid-frame/mid-ramp discards in-flight pixels and ramp progress.
//  Pipeline: 2 register stages, latency 2 cycles accept->out_valid. Global enable en = out_ready | ~out_valid;
//   in_ready = en. Accept = in_valid & in_ready. Stall holds out_data/out_valid/out_sof stable while out_valid&~out_ready.
//  Gain FSM (states HOLD, UP, DOWN), evaluated only on an accepted SOF pixel:
//   target <= (level+1)<<FRAC_W; next = cur +/- RAMP_STEP toward target, clamped (never overshoots);
//   RAMP_STEP=0 -> next=target. The SOF pixel itself and rest of frame use next.
//   state after update: HOLD if next==target, UP if next<target, DOWN if next>target. level changes mid-frame ignored.
//   ramp_busy = (state!=HOLD). Non-SOF pixels never change gain.
//  Stage 1: register pixel, sof, gain snapshot. Stage 2 per channel:
//   p = ch * gain (CH_W+LVL_W+FRAC_W+1 bits, no overflow); s = p >> FRAC_W;
//   out = (s > 2^CH_W-1) ? 2^CH_W-1 : s[CH_W-1:0]. Channels independent; zero in -> zero out.
//  Simultaneous SOF accept and output stall: gain update still applies to the accepted pixel only.
// CONFIGURATION
//  BRIGHTNESS_ROUND_EN defined: s = (p + 2^(FRAC_W-1)) >> FRAC_W (round half up) before saturation.
//  Not defined: truncation (floor). FRAC_W=0 makes both identical.
// TESTING (CH_W=4, NUM_CH=3, LVL_W=3, FRAC_W=2, RAMP_STEP=1)
//  1 Reset, level=0, SOF pixel 0xA5F, out_ready=1 -> 2 cycles later out_data=0xA5F, gain_cur=4, ramp_busy=0.
//  2 level=1, SOF pixel 0xA00 -> gain_cur=5, state UP; out 0xC00 (10*5>>2=12); with ROUND_EN out 0xD00.
//  3 Saturation: gain 8 (level=1 after 4 frames), pixel 0xF81 -> 0xFF2; gain_cur stays 8, ramp_busy=0 from frame 4.
//  4 level 7 -> 0 mid-frame: no gain change until next SOF; then steps 32->31->... DOWN, reaching 4 after 28 SOFs.
//  5 out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data held, no pixel lost/duplicated (scoreboard).
//  6 rst_n=0 mid-ramp (gain 6, busy) -> next cycle out_valid=0, gain_cur=4, ramp_busy=0; RAMP_STEP=0 build: SOF level=3 -> gain_cur=16 immediately.

Source files
------------

// File: rtl/brightness_gain_ramp.sv
// brightness_gain_ramp: per-channel brightness scaler with saturating fixed-point gain
// that ramps toward a level-derived target once per frame (at SOF), valid/ready streamed.
// Optional build macro BRIGHTNESS_ROUND_EN: round half up before saturation (default: truncate).
// Ports:
//   clk, rst_n                 pixel clock, synchronous active-low reset
//   in_data_i/in_sof_i/in_valid_i/in_ready_o   input pixel stream (in_sof_i marks first pixel)
//   level_i                    brightness level, target gain = level+1, sampled on accepted SOF
//   out_data_o/out_sof_o/out_valid_o/out_ready_i output pixel stream, latency 2
//   gain_cur_o                 current gain, FRAC_W fractional bits
//   ramp_busy_o                high while current gain differs from target
module brightness_gain_ramp #(
    parameter int CH_W      = 4,
    parameter int NUM_CH    = 3,
    parameter int LVL_W     = 3,
    parameter int FRAC_W    = 2,
    parameter int RAMP_STEP = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*CH_W-1:0]   in_data_i,
    input  logic                     in_sof_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [LVL_W-1:0]         level_i,
    output logic [NUM_CH*CH_W-1:0]   out_data_o,
    output logic                     out_sof_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [LVL_W+FRAC_W:0]    gain_cur_o,
    output logic                     ramp_busy_o
);
    localparam int GW = LVL_W + FRAC_W + 1;
    localparam int PW = CH_W + GW;
    localparam int DW = NUM_CH * CH_W;
    localparam logic [GW-1:0] STEP = GW'(RAMP_STEP);
    localparam logic [GW-1:0] ONE = GW'(1) << FRAC_W;
    localparam logic [PW-1:0] MAX = PW'((2 ** CH_W) - 1);
`ifdef BRIGHTNESS_ROUND_EN
    localparam logic [PW-1:0] RND = PW'((2 ** FRAC_W) / 2);
`else
    localparam logic [PW-1:0] RND = '0;
`endif
    typedef enum logic [1:0] {HOLD, UP, DOWN} state_t;
    state_t          state_q;
    logic [GW-1:0]   gain_q, gain_d, target_d, s1_gain_q;
    logic [DW-1:0]   s1_data_q, out_data_q, scaled;
    logic            s1_valid_q, s1_sof_q, out_valid_q, out_sof_q;
    logic            en, acc, upd;
    // whole pipeline advances together; it only freezes while a pixel waits at the output
    assign en          = out_ready_i | ~out_valid_q;
    assign acc         = in_valid_i & en;
    assign upd         = acc & in_sof_i;
    assign in_ready_o  = en;
    assign out_data_o  = out_data_q;
    assign out_sof_o   = out_sof_q;
    assign out_valid_o = out_valid_q;
    assign gain_cur_o  = gain_q;
    assign ramp_busy_o = state_q != HOLD;
    assign target_d = (GW'(level_i) + GW'(1)) << FRAC_W;
    // one step toward target, clamped so it never overshoots
    assign gain_d = (RAMP_STEP == 0) ? target_d
                  : (target_d > gain_q) ? ((target_d - gain_q > STEP) ? gain_q + STEP : target_d)
                  : (gain_q - target_d > STEP) ? gain_q - STEP : target_d;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gain_q  <= ONE;
            state_q <= HOLD;
        end else if (upd) begin
            gain_q  <= gain_d;
            state_q <= (gain_d == target_d) ? HOLD : (gain_d < target_d) ? UP : DOWN;
        end
    end
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PW-1:0] p, s;
        assign p = PW'(s1_data_q[c*CH_W +: CH_W]) * PW'(s1_gain_q);
        assign s = (p + RND) >> FRAC_W;
        assign scaled[c*CH_W +: CH_W] = (s > MAX) ? MAX[CH_W-1:0] : s[CH_W-1:0];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_data_q   <= '0;
            s1_gain_q   <= ONE;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_data_q  <= '0;
        end else if (en) begin
            s1_valid_q  <= in_valid_i;
            s1_sof_q    <= in_sof_i & in_valid_i;
            s1_data_q   <= in_data_i;
            // an accepted SOF pixel already uses the freshly stepped gain
            s1_gain_q   <= upd ? gain_d : gain_q;
            out_valid_q <= s1_valid_q;
            out_sof_q   <= s1_sof_q;
            out_data_q  <= scaled;
        end
    end
endmodule
